// File: rtl/arith_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default widths
// and the counter-width helper.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int DIVIDEND_W_DEF = 16;
   localparam int DIVISOR_W_DEF  = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/u_seq_div16by8_if.sv
// Operand/result handshake bundle for the sequential divider.
interface u_seq_div16by8_if
   import arith_pkg::*;
#(
   parameter int N_DIVIDEND = DIVIDEND_W_DEF,
   parameter int N_DIVISOR  = DIVISOR_W_DEF
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [N_DIVIDEND-1:0] dividend;
   logic [N_DIVISOR-1:0]  divisor;
   logic                  out_valid;
   logic                  out_ready;
   logic [N_DIVIDEND-1:0] quotient;
   logic [N_DIVISOR-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/u_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it does not borrow.
module u_div_step #(
   parameter int N_DIVISOR = 8
) (
   input  logic [N_DIVISOR:0]   r_in,
   input  logic                 q_msb,
   input  logic [N_DIVISOR-1:0] d,
   output logic [N_DIVISOR:0]   r_out,
   output logic                 q_bit
);

   // r_in is always < d, so its top bit is zero and the top bit of diff is the borrow.
   logic signed [N_DIVISOR+1:0] diff;

   assign diff  = $signed({r_in, q_msb}) - $signed({2'b00, d});
   assign q_bit = ~diff[N_DIVISOR+1];
   assign r_out = q_bit ? diff[N_DIVISOR:0] : {r_in[N_DIVISOR-1:0], q_msb};

endmodule

// File: rtl/u_seq_div16by8.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on operands and result.
module u_seq_div16by8
   import arith_pkg::*;
#(
   parameter int N_DIVIDEND = DIVIDEND_W_DEF,
   parameter int N_DIVISOR  = DIVISOR_W_DEF
) (
   input logic             clk,
   input logic             rst,
   u_seq_div16by8_if.slave bus
);

   localparam int CNT_W = clog2(N_DIVIDEND + 1);

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [N_DIVIDEND-1:0] q_sh;
   logic [N_DIVISOR:0]    r_part;
   logic [N_DIVISOR-1:0]  d_reg;
   logic                  dz_flag;
   logic                  in_ready_r;
   logic                  out_valid_r;
   logic [N_DIVIDEND-1:0] quotient_r;
   logic [N_DIVISOR-1:0]  remainder_r;
   logic                  dbz_r;
   logic [N_DIVISOR:0]    r_next;
   logic                  q_bit;

   u_div_step #(.N_DIVISOR(N_DIVISOR)) u_step (
      .r_in  (r_part),
      .q_msb (q_sh[N_DIVIDEND-1]),
      .d     (d_reg),
      .r_out (r_next),
      .q_bit (q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         q_sh        <= '0;
         r_part      <= '0;
         d_reg       <= '0;
         dz_flag     <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dbz_r       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  q_sh       <= bus.dividend;
                  d_reg      <= bus.divisor;
                  r_part     <= '0;
                  dz_flag    <= 1'b0;
                  cnt        <= CNT_W'(N_DIVIDEND);
                  in_ready_r <= 1'b0;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               // A zero divisor skips the iterations and reports the saturated result.
               if (d_reg == '0) begin
                  q_sh    <= '1;
                  r_part  <= '0;
                  dz_flag <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  r_part <= r_next;
                  q_sh   <= {q_sh[N_DIVIDEND-2:0], q_bit};
                  cnt    <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_valid_r && bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  out_valid_r <= 1'b1;
                  quotient_r  <= q_sh;
                  remainder_r <= r_part[N_DIVISOR-1:0];
                  dbz_r       <= dz_flag;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_u_seq_div16by8.sv
// Directed-vector and randomized bench for the sequential 16/8 divider.
module tb_u_seq_div16by8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   u_seq_div16by8_if #(.N_DIVIDEND(16), .N_DIVISOR(8)) bus ();

   u_seq_div16by8 #(.N_DIVIDEND(16), .N_DIVISOR(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Handshake one division, wait for the result, capture it, then consume it.
   task automatic do_div(input logic [15:0] a, input logic [7:0] b, input bit rnd,
                         output logic [15:0] q, output logic [7:0] r, output logic dz,
                         output int lat);
      int  guard;
      bit  done;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      bus.dividend  = a;
      bus.divisor   = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      q  = bus.quotient;
      r  = bus.remainder;
      dz = bus.div_by_zero;
      if (lat >= 100) begin
         check("result_timeout", 32'(lat), 32'd17);
         return;
      end
      done  = 1'b0;
      guard = 0;
      while (!done && guard < 50) begin
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         done = bus.out_ready;
         @(posedge clk); #1; guard++;
      end
      bus.out_ready = 1'b1;
   endtask

   logic [15:0] q;
   logic [7:0]  r;
   logic        dz;
   int          lat;
   logic [15:0] ra;
   logic [7:0]  rb;
   int          bad;

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b0;

      vecs[0]  = '{16'd1000,  8'd7,    16'd142,   8'd6,   1'b0, 17};
      vecs[1]  = '{16'hFE01,  8'hFF,   16'h00FF,  8'd0,   1'b0, 17};
      vecs[2]  = '{16'h0800,  8'h01,   16'h0800,  8'd0,   1'b0, 17};
      vecs[3]  = '{16'h1234,  8'h00,   16'hFFFF,  8'd0,   1'b1, 2};
      vecs[4]  = '{16'hFFFF,  8'h10,   16'h0FFF,  8'h0F,  1'b0, 17};
      vecs[5]  = '{16'hABCD,  8'h03,   16'h3944,  8'd1,   1'b0, 17};
      vecs[6]  = '{16'h0000,  8'hFF,   16'h0000,  8'd0,   1'b0, 17};
      vecs[7]  = '{16'hFFFF,  8'hFF,   16'h0101,  8'd0,   1'b0, 17};
      vecs[8]  = '{16'hFFFF,  8'h01,   16'hFFFF,  8'd0,   1'b0, 17};
      vecs[9]  = '{16'd100,   8'd200,  16'd0,     8'd100, 1'b0, 17};
      vecs[10] = '{16'h1234,  8'hFF,   16'd18,    8'd70,  1'b0, 17};
      vecs[11] = '{16'd12345, 8'd123,  16'd100,   8'd45,  1'b0, 17};

      #12;
      check("rst_in_ready",    32'(bus.in_ready),    32'd1);
      check("rst_out_valid",   32'(bus.out_valid),   32'd0);
      check("rst_quotient",    32'(bus.quotient),    32'd0);
      check("rst_remainder",   32'(bus.remainder),   32'd0);
      check("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         do_div(vecs[i].a, vecs[i].b, 1'b0, q, r, dz, lat);
         check($sformatf("vec%0d_latency", i),   32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_quotient", i),  32'(q),   32'(vecs[i].q));
         check($sformatf("vec%0d_remainder", i), 32'(r),   32'(vecs[i].r));
         check($sformatf("vec%0d_dbz", i),       32'(dz),  32'(vecs[i].dz));
         check($sformatf("vec%0d_ovalid_low", i), 32'(bus.out_valid), 32'd0);
         check($sformatf("vec%0d_iready_back", i), 32'(bus.in_ready), 32'd1);
         check($sformatf("vec%0d_q_held", i),    32'(bus.quotient), 32'(vecs[i].q));
      end

      // Backpressure: result held for 5 stalled cycles, new operands refused.
      bus.dividend  = 16'hFFFF;
      bus.divisor   = 8'h10;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      check("bp_latency", 32'(lat), 32'd17);
      bus.dividend = 16'h0042;
      bus.divisor  = 8'h02;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_valid_%0d", k),    32'(bus.out_valid), 32'd1);
         check($sformatf("bp_quotient_%0d", k), 32'(bus.quotient),  32'h0FFF);
         check($sformatf("bp_rem_%0d", k),      32'(bus.remainder), 32'h0F);
         check($sformatf("bp_in_ready_%0d", k), 32'(bus.in_ready),  32'd0);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_consumed", 32'(bus.out_valid), 32'd0);
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.out_valid || !bus.in_ready) bad++;
      end
      check("bp_not_queued", 32'(bad), 32'd0);

      // Asynchronous reset six cycles into a division.
      bus.dividend = 16'hABCD;
      bus.divisor  = 8'h03;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready",  32'(bus.in_ready),    32'd1);
      check("mid_rst_out_valid", 32'(bus.out_valid),   32'd0);
      check("mid_rst_quotient",  32'(bus.quotient),    32'd0);
      check("mid_rst_remainder", 32'(bus.remainder),   32'd0);
      check("mid_rst_dbz",       32'(bus.div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.out_valid) bad++;
      end
      check("mid_rst_discarded", 32'(bad), 32'd0);
      do_div(16'hABCD, 8'h03, 1'b0, q, r, dz, lat);
      check("post_rst_quotient",  32'(q), 32'h3944);
      check("post_rst_remainder", 32'(r), 32'd1);

      // Randomized regression with corner operands and random consumer stalls.
      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 7))
            0:       rb = 8'h01;
            1:       rb = 8'hFF;
            2:       rb = 8'h00;
            default: rb = 8'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       ra = 16'h0000;
            1:       ra = 16'hFFFF;
            default: ra = 16'($urandom);
         endcase
         do_div(ra, rb, 1'b1, q, r, dz, lat);
         if (rb == 8'h00)
            check($sformatf("rand%0d_zero a=%0h", n, ra), {q, r, 7'd0, dz},
                  {16'hFFFF, 8'h00, 7'd0, 1'b1});
         else
            check($sformatf("rand%0d a=%0h b=%0h q=%0h r=%0h", n, ra, rb, q, r),
                  32'((32'(q) * 32'(rb) + 32'(r) == 32'(ra)) && (r < rb) && !dz), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
